nw_fill_controller: RTL

- Sequencer for the Needleman-Wunsch score-matrix fill phase. Starts after the sequence-insertion counter reports end of filling.
- Writes the gap-penalty boundary row and column into the score RAM.
- Walks the interior cells (i,j), i,j = 1..N, in row-major order. For each cell it reads the diag/up/left neighbours, hands them to the scoring PE through a start/done handshake, and writes the result back.
- Owns the single score-RAM port during the fill phase.

---
 rtl/nw_pkg.sv | 27 ++
 rtl/nw_addr_calc.sv | 19 +
 rtl/nw_fill_controller.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/nw_pkg.sv
// Shared definitions for the Needleman-Wunsch blocks: score width, gap default,
// fill-sequencer state encoding and the score-RAM address width derivation.
package nw_pkg;

    localparam int NW_W   = 8;
    localparam int NW_GAP = -2;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_INIT_ROW = 4'd1,
        ST_INIT_COL = 4'd2,
        ST_RD_DIAG  = 4'd3,
        ST_RD_UP    = 4'd4,
        ST_RD_LEFT  = 4'd5,
        ST_CAP_LEFT = 4'd6,
        ST_PE_START = 4'd7,
        ST_PE_WAIT  = 4'd8,
        ST_WRITE    = 4'd9,
        ST_DONE     = 4'd10
    } fill_state_e;

    // Address width of an (n+1)x(n+1) score matrix stored row-major.
    function automatic int addr_w(input int n);
        return $clog2((n + 1) * (n + 1));
    endfunction

endpackage

// File: rtl/nw_addr_calc.sv
// Row-major score-matrix address: addr = row*(N+1) + col.
module nw_addr_calc
    import nw_pkg::*;
#(
    parameter int N       = 2,
    parameter int BitAddr = $clog2(N + 1),
    parameter int ADDR_W  = addr_w(N)
) (
    input  logic [BitAddr:0]  row,
    input  logic [BitAddr:0]  col,
    output logic [ADDR_W-1:0] addr
);

    // Pure combinational index-to-address mapping.
    always_comb begin
        addr = ADDR_W'(32'(row) * (N + 1) + 32'(col));
    end

endmodule

// File: rtl/nw_fill_controller.sv
// Score-matrix fill sequencer: writes gap boundaries, then walks interior cells
// row-major, fetching neighbours for the scoring PE and writing back its result.
module nw_fill_controller
    import nw_pkg::*;
#(
    parameter int N       = 2,
    parameter int BitAddr = $clog2(N + 1),
    parameter int ADDR_W  = addr_w(N),
    parameter int W       = NW_W,
    parameter int GAP     = NW_GAP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [W-1:0]      ram_wdata,
    input  logic [W-1:0]      ram_rdata,
    output logic              pe_start,
    output logic [W-1:0]      pe_diag,
    output logic [W-1:0]      pe_up,
    output logic [W-1:0]      pe_left,
    input  logic              pe_done,
    input  logic [W-1:0]      pe_score,
    output logic [BitAddr:0]  i,
    output logic [BitAddr:0]  j,
    output logic              busy,
    output logic              done
);

    localparam int            IW    = BitAddr + 1;
    localparam logic [IW-1:0] LAST  = IW'(N);
    localparam logic [IW-1:0] ONE   = IW'(1);
    localparam logic [W-1:0]  GAP_W = W'(GAP);

    fill_state_e       state_r;
    logic [W-1:0]      gap_r;
    logic [IW-1:0]     nxt_row_s;
    logic [IW-1:0]     nxt_col_s;
    logic [ADDR_W-1:0] nxt_addr_s;

    // Matrix coordinate the RAM port must present in the following cycle,
    // so that ram_addr can be registered alongside the state it belongs to.
    always_comb begin
        nxt_row_s = i;
        nxt_col_s = j;
        case (state_r)
            ST_IDLE: begin
                nxt_row_s = '0;
                nxt_col_s = '0;
            end
            ST_INIT_ROW: begin
                if (j == LAST) begin
                    nxt_row_s = ONE;
                    nxt_col_s = '0;
                end else begin
                    nxt_row_s = '0;
                    nxt_col_s = j + ONE;
                end
            end
            ST_INIT_COL: begin
                if (i == LAST) begin
                    nxt_row_s = '0;
                    nxt_col_s = '0;
                end else begin
                    nxt_row_s = i + ONE;
                    nxt_col_s = '0;
                end
            end
            ST_RD_DIAG: begin
                nxt_row_s = i - ONE;
                nxt_col_s = j;
            end
            ST_RD_UP: begin
                nxt_row_s = i;
                nxt_col_s = j - ONE;
            end
            ST_WRITE: begin
                // Diagonal of the next cell: (i-1,j) along a row, (i,0) on wrap.
                if (j != LAST) begin
                    nxt_row_s = i - ONE;
                    nxt_col_s = j;
                end else if (i != LAST) begin
                    nxt_row_s = i;
                    nxt_col_s = '0;
                end else begin
                    nxt_row_s = i;
                    nxt_col_s = j;
                end
            end
            default: begin
                nxt_row_s = i;
                nxt_col_s = j;
            end
        endcase
    end

    nw_addr_calc #(
        .N       (N),
        .BitAddr (BitAddr),
        .ADDR_W  (ADDR_W)
    ) u_addr_calc (
        .row  (nxt_row_s),
        .col  (nxt_col_s),
        .addr (nxt_addr_s)
    );

    // Fill FSM with all outputs registered for the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            gap_r     <= '0;
            ram_addr  <= '0;
            ram_we    <= 1'b0;
            ram_wdata <= '0;
            pe_start  <= 1'b0;
            pe_diag   <= '0;
            pe_up     <= '0;
            pe_left   <= '0;
            i         <= '0;
            j         <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            ram_addr <= nxt_addr_s;
            ram_we   <= 1'b0;
            pe_start <= 1'b0;
            done     <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r   <= ST_INIT_ROW;
                        i         <= '0;
                        j         <= '0;
                        gap_r     <= GAP_W;
                        ram_we    <= 1'b1;
                        ram_wdata <= '0;
                        busy      <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_INIT_ROW: begin
                    ram_we <= 1'b1;
                    if (j == LAST) begin
                        // Column boundary restarts the accumulator at one gap.
                        state_r   <= ST_INIT_COL;
                        i         <= ONE;
                        j         <= '0;
                        ram_wdata <= GAP_W;
                        gap_r     <= GAP_W + GAP_W;
                    end else begin
                        j         <= j + ONE;
                        ram_wdata <= gap_r;
                        gap_r     <= gap_r + GAP_W;
                    end
                end
                ST_INIT_COL: begin
                    if (i == LAST) begin
                        state_r <= ST_RD_DIAG;
                        i       <= ONE;
                        j       <= ONE;
                    end else begin
                        i         <= i + ONE;
                        ram_we    <= 1'b1;
                        ram_wdata <= gap_r;
                        gap_r     <= gap_r + GAP_W;
                    end
                end
                ST_RD_DIAG: begin
                    state_r <= ST_RD_UP;
                end
                ST_RD_UP: begin
                    pe_diag <= ram_rdata;
                    state_r <= ST_RD_LEFT;
                end
                ST_RD_LEFT: begin
                    pe_up   <= ram_rdata;
                    state_r <= ST_CAP_LEFT;
                end
                ST_CAP_LEFT: begin
                    pe_left  <= ram_rdata;
                    pe_start <= 1'b1;
                    state_r  <= ST_PE_START;
                end
                ST_PE_START: begin
                    state_r <= ST_PE_WAIT;
                end
                ST_PE_WAIT: begin
                    if (pe_done) begin
                        ram_we    <= 1'b1;
                        ram_wdata <= pe_score;
                        state_r   <= ST_WRITE;
                    end else begin
                        state_r <= ST_PE_WAIT;
                    end
                end
                ST_WRITE: begin
                    if (j != LAST) begin
                        j       <= j + ONE;
                        state_r <= ST_RD_DIAG;
                    end else if (i != LAST) begin
                        i       <= i + ONE;
                        j       <= ONE;
                        state_r <= ST_RD_DIAG;
                    end else begin
                        done    <= 1'b1;
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
